// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared sizes, stream header value and loader state type
// Holds the parameter defaults used by weight_loader and wl_checksum.
`timescale 1ns/1ps
package bnn_pkg;

    localparam int WT_W   = 16;   // width of every weight, bias and stream word
    localparam int NUM_WT = 6;    // four hidden-layer plus two output-layer weights
    localparam int NUM_B  = 3;    // biases

    // Start-of-packet marker; only recognised while idle.
    localparam logic [15:0] HEADER = 16'hB5A5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } wl_state_t;

endpackage

// File: rtl/wl_checksum.sv
// rtl/wl_checksum.sv - wrap-around running sum of payload words
// Built only when WL_CHECKSUM_EN is defined.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : zero the sum (takes priority over i_add)
//   i_add          : add i_data into the sum this cycle
//   i_data         : word to accumulate
//   o_sum          : current WT_W-bit modular sum
`timescale 1ns/1ps
`ifdef WL_CHECKSUM_EN
module wl_checksum
    import bnn_pkg::*;
#(
    parameter int WT_W = bnn_pkg::WT_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_add,
    input  logic [WT_W-1:0] i_data,
    output logic [WT_W-1:0] o_sum
);

    logic [WT_W-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            // Carry out of the top bit is intentionally dropped.
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule
`endif

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams a parameter packet into staging and commits it atomically
// Macro WL_CHECKSUM_EN: when defined the packet carries a trailing checksum word
// that is verified before commit; when undefined the packet is header + payload only.
// Ports:
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   in_valid/in_ready : stream handshake, word taken when both high on a rising edge
//   in_data           : signed stream word
//   wt, b             : live weights and biases (only ever a complete committed set)
//   params_valid      : live registers hold a committed set
//   load_ok, load_err : one-cycle pulses for commit / rejected header or checksum
//   busy              : loader is not idle
`timescale 1ns/1ps
module weight_loader
    import bnn_pkg::*;
#(
    parameter int WT_W   = bnn_pkg::WT_W,
    parameter int NUM_WT = bnn_pkg::NUM_WT,
    parameter int NUM_B  = bnn_pkg::NUM_B
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [WT_W-1:0] in_data,
    output logic signed [WT_W-1:0] wt [0:NUM_WT-1],
    output logic signed [WT_W-1:0] b  [0:NUM_B-1],
    output logic                   params_valid,
    output logic                   load_ok,
    output logic                   load_err,
    output logic                   busy
);

    localparam int              NUM_WORDS = NUM_WT + NUM_B;
    localparam int              IDX_W     = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [WT_W-1:0]  HDR      = WT_W'(HEADER);

    wl_state_t               r_state;
    logic [IDX_W-1:0]        r_idx;
    logic signed [WT_W-1:0]  r_stg [0:NUM_WORDS-1];
    logic signed [WT_W-1:0]  r_wt  [0:NUM_WT-1];
    logic signed [WT_W-1:0]  r_b   [0:NUM_B-1];
    logic                    r_params_valid;
    logic                    r_load_ok;
    logic                    r_load_err;

    logic w_accept;
    logic w_is_hdr;

    // COMMIT is the only cycle where the loader cannot take a word.
    assign in_ready = (r_state != ST_COMMIT);
    assign w_accept = in_valid & in_ready;
    assign w_is_hdr = ($unsigned(in_data) == HDR);

`ifdef WL_CHECKSUM_EN
    logic            w_sum_clr;
    logic            w_sum_add;
    logic [WT_W-1:0] w_sum;

    // Header itself is never summed; each accepted header restarts the sum.
    assign w_sum_clr = w_accept && (r_state == ST_IDLE) && w_is_hdr;
    assign w_sum_add = w_accept && (r_state == ST_RECV);

    wl_checksum #(
        .WT_W (WT_W)
    ) u_checksum (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_sum_clr),
        .i_add   (w_sum_add),
        .i_data  ($unsigned(in_data)),
        .o_sum   (w_sum)
    );
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_params_valid <= 1'b0;
            r_load_ok      <= 1'b0;
            r_load_err     <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) r_stg[i] <= '0;
            for (int i = 0; i < NUM_WT; i++)    r_wt[i]  <= '0;
            for (int i = 0; i < NUM_B; i++)     r_b[i]   <= '0;
        end else begin
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_hdr) begin
                            r_state <= ST_RECV;
                            r_idx   <= '0;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    // Any value, including HEADER, is payload here.
                    if (w_accept) begin
                        r_stg[r_idx] <= in_data;
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
`ifdef WL_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_COMMIT;
`endif
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
`ifdef WL_CHECKSUM_EN
                    if (w_accept) begin
                        if ($unsigned(in_data) == w_sum) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            // Staging is abandoned; live set stays as it was.
                            r_load_err <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_COMMIT: begin
                    // Whole set moves in one edge so consumers never see a mix.
                    for (int i = 0; i < NUM_WT; i++) r_wt[i] <= r_stg[i];
                    for (int i = 0; i < NUM_B; i++)  r_b[i]  <= r_stg[NUM_WT + i];
                    r_params_valid <= 1'b1;
                    r_load_ok      <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wt           = r_wt;
    assign b            = r_b;
    assign params_valid = r_params_valid;
    assign load_ok      = r_load_ok;
    assign load_err     = r_load_err;
    assign busy         = (r_state != ST_IDLE);

endmodule
